// File: rtl/camera_pkg.sv
// Shared types and constants for the synthetic camera source.
package camera_pkg;

    typedef enum logic [1:0] {
        RAMP    = 2'd0,
        BARS    = 2'd1,
        CHECKER = 2'd2,
        LFSR    = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Taps at bits 7,5,4,3 feed the new bit 0.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// Test-pattern pixel function plus the LFSR that backs the LFSR pattern.
module camera_pattern_gen
    import camera_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pattern,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] pixel
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_cur;

    // A load shows the seed on the very pixel that loads it.
    assign lfsr_cur = load ? LFSR_SEED : lfsr_q;

    // Pixel value for the coordinate about to be emitted.
    always_comb begin
        pixel = 8'h00;
        case (pattern_e'(pattern))
            RAMP:    pixel = x + y;
            BARS:    pixel = {x[5:3], 5'b0};
            CHECKER: pixel = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            LFSR:    pixel = lfsr_cur;
            default: pixel = 8'h00;
        endcase
    end

    // LFSR steps once per emitted pixel and holds through blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= LFSR_SEED;
        else if (advance)
            lfsr_q <= lfsr_next(lfsr_cur);
    end

endmodule

// File: rtl/camera_source.sv
// Synthetic raster sensor: frame/line timing FSM, counters and registered
// pixel-stream outputs. Coordinates x/y always name the pixel on the outputs.
module camera_source
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int V_ACTIVE = 48,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_valid,
    output logic        cam_sof,
    output logic        cam_eol,
    output logic [7:0]  cam_pixel,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

    state_e        state;
    logic [XW-1:0] x, px_x;
    logic [YW-1:0] y, px_y;
    logic [BW-1:0] bcnt;
    logic [1:0]    pat, px_pat;
    logic          frame_start, line_start, emit;
    logic [7:0]    pix;

    // Decide whether a pixel is emitted after this edge and which one.
    always_comb begin
        frame_start = ((state == IDLE) || (state == VBLANK && bcnt == VB_LAST)) && enable;
        line_start  = (state == HBLANK) && (bcnt == HB_LAST);
        emit        = frame_start || line_start || (state == ACTIVE && x != X_LAST);
        px_x        = (frame_start || line_start) ? '0 : x + XW'(1);
        px_y        = frame_start ? '0 : (line_start ? y + YW'(1) : y);
        px_pat      = frame_start ? pattern_sel : pat;
    end

    camera_pattern_gen u_pattern (
        .clk     (clk),
        .rst_n   (rst_n),
        .pattern (px_pat),
        .x       (8'(px_x)),
        .y       (8'(px_y)),
        .load    (frame_start),
        .advance (emit),
        .pixel   (pix)
    );

    // Timing FSM with registered stream outputs; pattern latched per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            bcnt        <= '0;
            pat         <= '0;
            cam_valid   <= 1'b0;
            cam_sof     <= 1'b0;
            cam_eol     <= 1'b0;
            cam_pixel   <= 8'h00;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            cam_valid  <= emit;
            cam_sof    <= frame_start;
            cam_eol    <= emit && (px_x == X_LAST);
            frame_done <= emit && (px_x == X_LAST) && (px_y == Y_LAST);
            cam_pixel  <= emit ? pix : 8'h00;
            if (frame_start) begin
                frame_count <= frame_count + 16'd1;
                pat         <= pattern_sel;
            end
            if (emit) begin
                state <= ACTIVE;
                x     <= px_x;
                y     <= px_y;
            end else begin
                case (state)
                    ACTIVE: begin
                        state <= (y == Y_LAST) ? VBLANK : HBLANK;
                        bcnt  <= '0;
                    end
                    HBLANK: bcnt <= bcnt + BW'(1);
                    VBLANK: begin
                        if (bcnt == VB_LAST)
                            state <= IDLE;
                        else
                            bcnt <= bcnt + BW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/camera_source.md
# camera_source

Synthetic camera sensor model that drives the pixel-stream interface (`cam_valid`, `cam_sof`, `cam_pixel`) consumed by the capture front end. It emits raster frames with programmable active size and blanking, and fills them with one of four test patterns. It sits in place of the physical sensor for simulation, bring-up and built-in self-test, and is looped directly into the capture path.

## Interface
- `H_ACTIVE`, default 64: active pixels per line; must be ≥ 2.
- `V_ACTIVE`, default 48: active lines per frame; must be ≥ 1.
- `H_BLANK`, default 16: idle cycles after each line except the last; must be ≥ 1.
- `V_BLANK`, default 32: idle cycles after the last line of a frame; must be ≥ 1.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: request continuous frame generation.
- `pattern_sel` in 2: 0 = ramp, 1 = bars, 2 = checker, 3 = LFSR.
- `cam_valid` out 1: pixel qualifier.
- `cam_sof` out 1: high with pixel (0,0) of each frame.
- `cam_eol` out 1: high with the last pixel of each line.
- `cam_pixel` out 8: pixel value.
- `frame_done` out 1: one-cycle pulse with the last pixel of each frame.
- `frame_count` out 16: number of frames started (SOFs emitted); wraps.

## Operation
- States:
  - IDLE: no output activity.
  - ACTIVE: emitting pixels.
  - HBLANK: gap between lines.
  - VBLANK: gap between frames.
- Transitions:
  - IDLE → ACTIVE when `enable` is 1 at a clock edge.
  - ACTIVE → HBLANK after pixel `x = H_ACTIVE-1` when `y < V_ACTIVE-1`.
  - ACTIVE → VBLANK after the last pixel of the last line.
  - HBLANK → ACTIVE after `H_BLANK` cycles, with `y + 1`.
  - VBLANK → ACTIVE (new frame) after `V_BLANK` cycles if `enable` = 1; otherwise → IDLE.
- `enable` deasserted mid-frame: the current frame completes in full, including VBLANK. Frames are never truncated.
- `pattern_sel` is sampled only when a frame starts and is held for the whole frame.
- Counters `x` and `y` have width `$clog2(H_ACTIVE)` and `$clog2(V_ACTIVE)`. Pattern math uses their low 8 bits, zero-extended if narrower.
- Patterns (all results mod 256):
  - Ramp: `x + y`.
  - Bars: `{x[5:3], 5'b0}`.
  - Checker: `x[3] ^ y[3] ? 8'hFF : 8'h00`.
  - LFSR: register loaded with 8'h01 at each SOF. The SOF pixel shows 8'h01. After each emitted pixel it advances as `next = {l[6:0], l[7]^l[5]^l[4]^l[3]}`. It is held during blanking.
- `frame_count` increments in the same cycle `cam_sof` is asserted.

## Timing
- All outputs are registered.
- Reset values: `cam_valid`, `cam_sof`, `cam_eol` and `frame_done` = 0; `cam_pixel` = 8'h00; `frame_count` = 0; state = IDLE; LFSR = 8'h01.
- Latency: if `enable` is sampled high in IDLE at edge k, pixel (0,0) with `cam_sof` = 1 is on the outputs after edge k.
- Line period is `H_ACTIVE + H_BLANK` cycles.
- Frame period is `V_ACTIVE*(H_ACTIVE+H_BLANK) - H_BLANK + V_BLANK` cycles. There are no gap cycles between VBLANK and the next SOF.
- `cam_pixel` is don't-care when `cam_valid` = 0, but it must be driven 8'h00.
- `cam_sof`, `cam_eol` and `frame_done` are asserted only when `cam_valid` = 1.
- When `V_ACTIVE` = 1, `cam_sof`, `cam_eol` and `frame_done` coincide as described: SOF on the first pixel, EOL and `frame_done` on the last.
- Asynchronous reset mid-frame: all outputs return to reset values immediately. Generation resumes only on a fresh IDLE → ACTIVE transition.
- `frame_count` wraps from 16'hFFFF to 0 with no flag.

## Structure
- Shared package `camera_pkg` holds:
  - the `pattern_e` enum (RAMP, BARS, CHECKER, LFSR);
  - the LFSR seed constant 8'h01;
  - the tap mask constant 8'hB8;
  - the state enum.
- One natural sub-module, `camera_pattern_gen`: a combinational pixel function of (`pattern`, `x`, `y`, `lfsr`) plus the LFSR register with load/advance controls.
- Timing control, counters and the FSM stay in `camera_source`.

## Test plan
Use parameters `H_ACTIVE`=4, `H_BLANK`=2, `V_ACTIVE`=3, `V_BLANK`=5 unless stated otherwise.
- **Ramp frame:** `enable`=1, `pattern_sel`=0 → pixels 0,1,2,3 / 1,2,3,4 / 2,3,4,5. `cam_sof` on the first pixel, `cam_eol` every 4th pixel, `frame_done` on the value 5, next SOF 21 cycles after the first.
- **LFSR:** `pattern_sel`=3 → the first five pixels are 01,02,04,08,11. The sequence reloads 01 at the next SOF.
- **Graceful stop:** drop `enable` at pixel (1,1) → the frame completes (12 pixels), VBLANK completes, then IDLE with no further SOF and `frame_count`=1.
- **Pattern latch:** switch `pattern_sel` 0→2 mid-frame → the current frame stays ramp. The next frame is checker; with `H_ACTIVE`=16 its row 0 is x 0–7 = 00 and x 8–15 = FF.
- **Reset mid-line:** assert `rst_n`=0 at pixel (2,0) → all outputs 0 asynchronously. After release with `enable`=1, a new SOF appears with `frame_count`=1.
- **Loopback:** feed the outputs into the capture block and run 3 frames → the capture frame counter reads 3, and the captured pixel count equals 36.
